dma_irq_ctrl: RTL and testbench

Interrupt controller for the AXI4 DMA. Latches per-channel done and error events into sticky status bits and applies a per-channel mask. Coalesces done events by count or timeout; errors are never coalesced. Drives a single CPU interrupt with a prioritised channel vector, using an assert/acknowledge handshake and write-1-to-clear.

---
 rtl/dma_irq_if.sv | 33 +++
 rtl/dma_irq_ctrl.sv | 120 ++++++++++++
 tb/tb_dma_irq_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_irq_if.sv
// Signal bundle between the DMA interrupt controller and its DMA/CPU side.
// The slave modport is the controller; the master modport is the DMA engine plus CPU.
interface dma_irq_if #(
  parameter int NCH   = 6,
  parameter int CNT_W = 8
);
  logic [NCH-1:0]   ch_done;
  logic [NCH-1:0]   ch_err;
  logic [NCH-1:0]   cfg_mask;
  logic [CNT_W-1:0] cfg_coal_cnt;
  logic [CNT_W-1:0] cfg_coal_tmo;
  logic             clr_en;
  logic [NCH-1:0]   clr_done;
  logic [NCH-1:0]   clr_err;
  logic             irq;
  logic [2:0]       irq_vec;
  logic             irq_is_err;
  logic             irq_ack;
  logic [NCH-1:0]   st_done;
  logic [NCH-1:0]   st_err;

  modport slave (
    input  ch_done, ch_err, cfg_mask, cfg_coal_cnt, cfg_coal_tmo,
    input  clr_en, clr_done, clr_err, irq_ack,
    output irq, irq_vec, irq_is_err, st_done, st_err
  );

  modport master (
    output ch_done, ch_err, cfg_mask, cfg_coal_cnt, cfg_coal_tmo,
    output clr_en, clr_done, clr_err, irq_ack,
    input  irq, irq_vec, irq_is_err, st_done, st_err
  );
endinterface

// File: rtl/dma_irq_ctrl.sv
// DMA interrupt controller: sticky done/error status, done-event coalescing,
// and a single vectored CPU interrupt with ack and write-1-to-clear.
module dma_irq_ctrl #(
  parameter int NCH   = 6,
  parameter int CNT_W = 8
) (
  input  logic     clk,
  input  logic     resetn,
  dma_irq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COAL, ASSERT} state_t;

  state_t             state_reg;
  logic [NCH-1:0]     st_done_reg, st_err_reg;
  logic               irq_reg, is_err_reg;
  logic [2:0]         vec_reg;
  logic [CNT_W-1:0]   evt_cnt_reg, timer_reg;

  logic [NCH-1:0]     pend_err, pend_done, vec_onehot;
  logic [NCH-1:0]     clr_done_all, clr_err_all, st_done_next, st_err_next;
  logic               ack_fire, vec_held, vec_masked, new_done;

  function automatic logic [2:0] lowest(input logic [NCH-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign pend_err   = st_err_reg  & ~bus.cfg_mask;
  assign pend_done  = st_done_reg & ~bus.cfg_mask;
  assign ack_fire   = (state_reg == ASSERT) && bus.irq_ack;
  assign vec_onehot = {{(NCH-1){1'b0}}, 1'b1} << vec_reg;
  assign new_done   = |(bus.ch_done & ~bus.cfg_mask);

  // An ack clears only the bit the interrupt is currently vectored at.
  assign clr_done_all = ({NCH{bus.clr_en}} & bus.clr_done)
                      | ({NCH{ack_fire && !is_err_reg}} & vec_onehot);
  assign clr_err_all  = ({NCH{bus.clr_en}} & bus.clr_err)
                      | ({NCH{ack_fire && is_err_reg}} & vec_onehot);

  // New pulses are OR'ed in after the clear so a same-cycle set wins.
  assign st_done_next = (st_done_reg & ~clr_done_all) | bus.ch_done;
  assign st_err_next  = (st_err_reg  & ~clr_err_all)  | bus.ch_err;

  // Looking at next-state status lets a clear withdraw irq on the following cycle.
  assign vec_held   = is_err_reg ? |(st_err_next & vec_onehot) : |(st_done_next & vec_onehot);
  assign vec_masked = |(bus.cfg_mask & vec_onehot);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      st_done_reg <= '0;
      st_err_reg  <= '0;
      irq_reg     <= 1'b0;
      is_err_reg  <= 1'b0;
      vec_reg     <= '0;
      evt_cnt_reg <= '0;
      timer_reg   <= '0;
    end else begin
      st_done_reg <= st_done_next;
      st_err_reg  <= st_err_next;
      case (state_reg)
        IDLE: begin
          if (pend_err != '0) begin
            state_reg  <= ASSERT;
            irq_reg    <= 1'b1;
            is_err_reg <= 1'b1;
            vec_reg    <= lowest(pend_err);
          end else if (pend_done != '0) begin
            if (bus.cfg_coal_cnt <= CNT_W'(1)) begin
              state_reg  <= ASSERT;
              irq_reg    <= 1'b1;
              is_err_reg <= 1'b0;
              vec_reg    <= lowest(pend_done);
            end else begin
              state_reg   <= COAL;
              timer_reg   <= '0;
              evt_cnt_reg <= CNT_W'(1);
            end
          end
        end
        COAL: begin
          if (timer_reg != '1) timer_reg <= timer_reg + CNT_W'(1);
          if (new_done && evt_cnt_reg != '1) evt_cnt_reg <= evt_cnt_reg + CNT_W'(1);
          if (pend_err != '0) begin
            state_reg  <= ASSERT;
            irq_reg    <= 1'b1;
            is_err_reg <= 1'b1;
            vec_reg    <= lowest(pend_err);
          end else if (pend_done == '0) begin
            state_reg <= IDLE;
          end else if (evt_cnt_reg >= bus.cfg_coal_cnt || timer_reg == bus.cfg_coal_tmo) begin
            state_reg  <= ASSERT;
            irq_reg    <= 1'b1;
            is_err_reg <= 1'b0;
            vec_reg    <= lowest(pend_done);
          end
        end
        ASSERT: begin
          if (ack_fire || !vec_held || vec_masked) begin
            state_reg <= IDLE;
            irq_reg   <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.irq        = irq_reg;
  assign bus.irq_vec    = vec_reg;
  assign bus.irq_is_err = is_err_reg;
  assign bus.st_done    = st_done_reg;
  assign bus.st_err     = st_err_reg;

endmodule

// File: tb/tb_dma_irq_ctrl.sv
// Directed bench for dma_irq_ctrl: a timestamp-based behavioural model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_dma_irq_ctrl;
  localparam int NCH   = 6;
  localparam int CNT_W = 8;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  dma_irq_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  dma_irq_ctrl #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_irq(input string nm, input int budget);
    int n;
    n = 0;
    while (bus.irq !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(nm, 32'(bus.irq), 1);
  endtask

  // Behavioural model: sticky sets, a "serving" cause, and a coalescing window
  // tracked by its start timestamp and an event tally.
  logic [NCH-1:0] m_done, m_err;
  logic [NCH-1:0] t_cd, t_ce, t_nd, t_ne, t_pe, t_pd;
  bit             m_serving, m_iserr, m_coal, t_held;
  int             m_vec, m_evts, m_start, cyc, t_el;

  function automatic int first_set(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic serve(input logic [NCH-1:0] pe, input logic [NCH-1:0] pd);
    m_serving = 1'b1;
    if (pe != '0) begin
      m_iserr = 1'b1;
      m_vec   = first_set(pe);
    end else begin
      m_iserr = 1'b0;
      m_vec   = first_set(pd);
    end
  endtask

  initial begin
    m_done = '0; m_err = '0; m_serving = 0; m_iserr = 0; m_coal = 0;
    m_vec = 0; m_evts = 0; m_start = 0; cyc = 0;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        m_done = '0; m_err = '0; m_serving = 0; m_iserr = 0; m_coal = 0;
        m_vec = 0; m_evts = 0;
      end else begin
        t_pe = m_err  & ~bus.cfg_mask;
        t_pd = m_done & ~bus.cfg_mask;
        t_cd = bus.clr_en ? bus.clr_done : '0;
        t_ce = bus.clr_en ? bus.clr_err  : '0;
        if (m_serving && bus.irq_ack) begin
          if (m_iserr) t_ce[m_vec] = 1'b1;
          else         t_cd[m_vec] = 1'b1;
        end
        t_nd = (m_done & ~t_cd) | bus.ch_done;
        t_ne = (m_err  & ~t_ce) | bus.ch_err;
        if (m_serving) begin
          t_held = m_iserr ? t_ne[m_vec] : t_nd[m_vec];
          if (bus.irq_ack || !t_held || bus.cfg_mask[m_vec]) m_serving = 0;
        end else if (m_coal) begin
          t_el = cyc - m_start;
          if (t_el > 255) t_el = 255;
          if (t_pe != '0) begin
            m_coal = 0; serve(t_pe, t_pd);
          end else if (t_pd == '0) begin
            m_coal = 0;
          end else if (m_evts >= int'(bus.cfg_coal_cnt) || t_el == int'(bus.cfg_coal_tmo)) begin
            m_coal = 0; serve(t_pe, t_pd);
          end else if ((bus.ch_done & ~bus.cfg_mask) != '0 && m_evts < 255) begin
            m_evts = m_evts + 1;
          end
        end else if (t_pe != '0) begin
          serve(t_pe, t_pd);
        end else if (t_pd != '0) begin
          if (bus.cfg_coal_cnt <= 1) serve(t_pe, t_pd);
          else begin
            m_coal  = 1;
            m_start = cyc + 1;
            m_evts  = 1;
          end
        end
        m_done = t_nd;
        m_err  = t_ne;
        cyc++;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_irq", 32'(bus.irq), 32'(m_serving));
      if (m_serving) begin
        chk("cmp_vec", 32'(bus.irq_vec), 32'(m_vec));
        chk("cmp_is_err", 32'(bus.irq_is_err), 32'(m_iserr));
      end
      chk("cmp_st_done", 32'(bus.st_done), 32'(m_done));
      chk("cmp_st_err", 32'(bus.st_err), 32'(m_err));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0;
    resetn = 1'b0;
    bus.ch_done = '0; bus.ch_err = '0; bus.cfg_mask = '0;
    bus.cfg_coal_cnt = '0; bus.cfg_coal_tmo = '0;
    bus.clr_en = 1'b0; bus.clr_done = '0; bus.clr_err = '0; bus.irq_ack = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    chk("reset_irq", 32'(bus.irq), 0);
    chk("reset_st_done", 32'(bus.st_done), 0);
    chk("reset_st_err", 32'(bus.st_err), 0);
    repeat (6) tick();

    // Immediate error on channel 3.
    bus.ch_err = 6'b001000; tick(); bus.ch_err = '0;
    chk("err_status", 32'(bus.st_err), 32'h08);
    chk("err_irq_early", 32'(bus.irq), 0);
    tick();
    chk("err_irq", 32'(bus.irq), 1);
    chk("err_vec", 32'(bus.irq_vec), 3);
    chk("err_is_err", 32'(bus.irq_is_err), 1);
    repeat (3) tick();
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
    chk("err_ack_irq", 32'(bus.irq), 0);
    chk("err_ack_status", 32'(bus.st_err), 0);
    repeat (3) tick();

    // Error beats done; then the done is served after one idle cycle.
    bus.ch_done = 6'b000010; bus.ch_err = 6'b010000; tick();
    bus.ch_done = '0; bus.ch_err = '0; tick();
    chk("prio_vec1", 32'(bus.irq_vec), 4);
    chk("prio_err1", 32'(bus.irq_is_err), 1);
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
    chk("prio_gap_irq", 32'(bus.irq), 0);
    chk("prio_gap_done", 32'(bus.st_done), 32'h02);
    tick();
    chk("prio_irq2", 32'(bus.irq), 1);
    chk("prio_vec2", 32'(bus.irq_vec), 1);
    chk("prio_err2", 32'(bus.irq_is_err), 0);
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
    repeat (3) tick();
    chk("prio_quiet", 32'(bus.irq), 0);

    // Coalescing by count: three done events reach the threshold.
    bus.cfg_coal_cnt = 8'd3; bus.cfg_coal_tmo = 8'd50;
    for (int c = 0; c <= 11; c++) begin
      if (c == 10) chk("coal_cnt_early", 32'(bus.irq), 0);
      if (c == 11) begin
        chk("coal_cnt_irq", 32'(bus.irq), 1);
        chk("coal_cnt_vec", 32'(bus.irq_vec), 0);
      end
      bus.ch_done = (c == 0) ? 6'b000001 : (c == 4) ? 6'b000100 : (c == 9) ? 6'b100000 : 6'b000000;
      tick();
    end
    bus.ch_done = '0;
    chk("coal_cnt_status", 32'(bus.st_done), 32'h25);
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
    chk("coal_ack_irq", 32'(bus.irq), 0);
    chk("coal_ack_status", 32'(bus.st_done), 32'h24);
    wait_irq("coal_wait2", 200);
    chk("coal_vec2", 32'(bus.irq_vec), 2);
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
    wait_irq("coal_wait5", 200);
    chk("coal_vec5", 32'(bus.irq_vec), 5);
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
    repeat (4) tick();
    chk("coal_done_all", 32'(bus.st_done), 0);

    // Coalescing by timeout: a lone event waits for the timer.
    bus.cfg_coal_cnt = 8'd4; bus.cfg_coal_tmo = 8'd20;
    bus.ch_done = 6'b000100; tick(); bus.ch_done = '0;
    chk("tmo_status", 32'(bus.st_done), 32'h04);
    repeat (21) tick();
    chk("tmo_before", 32'(bus.irq), 0);
    tick();
    chk("tmo_irq", 32'(bus.irq), 1);
    chk("tmo_vec", 32'(bus.irq_vec), 2);
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
    repeat (3) tick();

    // Mask, ignored ack, and withdrawal by clear.
    bus.cfg_coal_cnt = 8'd0; bus.cfg_mask = 6'b000001;
    bus.ch_done = 6'b000001; tick(); bus.ch_done = '0;
    chk("mask_status", 32'(bus.st_done), 32'h01);
    repeat (2) tick();
    chk("mask_no_irq", 32'(bus.irq), 0);
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
    chk("idle_ack_ignored", 32'(bus.st_done), 32'h01);
    bus.ch_done = 6'b000010; tick(); bus.ch_done = '0; tick();
    chk("wd_irq", 32'(bus.irq), 1);
    chk("wd_vec", 32'(bus.irq_vec), 1);
    bus.clr_en = 1'b1; bus.clr_done = 6'b000010; tick();
    bus.clr_en = 1'b0; bus.clr_done = '0;
    chk("wd_dropped", 32'(bus.irq), 0);
    chk("wd_status", 32'(bus.st_done), 32'h01);
    tick();
    chk("wd_idle", 32'(bus.irq), 0);
    bus.clr_en = 1'b1; bus.clr_done = 6'b000001; tick();
    bus.clr_en = 1'b0; bus.clr_done = '0; bus.cfg_mask = '0;
    repeat (2) tick();

    // Set beats clear in the same cycle; asynchronous reset while asserted.
    bus.clr_en = 1'b1; bus.clr_done = 6'b000100; bus.ch_done = 6'b000100; tick();
    bus.clr_en = 1'b0; bus.clr_done = '0; bus.ch_done = '0;
    chk("collide_status", 32'(bus.st_done), 32'h04);
    tick();
    chk("collide_irq", 32'(bus.irq), 1);
    resetn = 1'b0;
    #1;
    chk("arst_irq", 32'(bus.irq), 0);
    chk("arst_st_done", 32'(bus.st_done), 0);
    chk("arst_st_err", 32'(bus.st_err), 0);
    repeat (2) tick();
    resetn = 1'b1;
    repeat (5) tick();
    chk("arst_no_irq", 32'(bus.irq), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
